// File: rtl/mix_columns_if.sv
// mix_columns_if
//   Block-level bus of the MixColumns engine.
//   Ports (as seen by the engine, modport slave):
//     in_valid   in   upstream offers a 128-bit state
//     in_ready   out  engine can take a block this cycle
//     in_state   in   input state, byte k = in_state[127-8k -: 8]
//     in_inverse in   0 = MixColumns, 1 = InvMixColumns
//     out_valid  out  result held on out_state
//     out_ready  in   downstream takes the result
//     out_state  out  transformed state
//     busy       out  block in flight (processing or waiting for output handshake)
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both 1. A source that raises valid keeps valid and its data unchanged
//   until that edge; ready may depend combinationally on state but never on
//   the valid of the same channel.
interface mix_columns_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_inverse;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   modport master (
      output in_valid, in_state, in_inverse, out_ready,
      input  in_ready, out_valid, out_state, busy
   );

   modport slave (
      input  in_valid, in_state, in_inverse, out_ready,
      output in_ready, out_valid, out_state, busy
   );
endinterface

// File: rtl/mix_columns_engine.sv
// mix_columns_engine
//   Iterative AES MixColumns / InvMixColumns on a full 128-bit state.
//   COLS_PER_CYCLE columns (1, 2 or 4) are transformed in place per clock,
//   so a block takes NCYC = 4/COLS_PER_CYCLE processing edges.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     bus        mix_columns_if.slave (input and output handshakes, busy)
//     fsm_state  current FSM state (IDLE=0, BUSY=1, DONE=2) for observation
module mix_columns_engine #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic           clk,
   input  logic           rst,
   mix_columns_if.slave   bus,
   output logic [1:0]     fsm_state
);

   localparam int NCYC = 4 / COLS_PER_CYCLE;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Value of col_cnt on the final processing edge of a block.
   localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   logic [1:0]   state;
   logic [127:0] work;
   logic [127:0] work_next;
   logic         inv_q;
   logic [1:0]   col_cnt;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // One column, rows 0..3 in col[31:24] .. col[7:0].
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0]  a  [4];
      logic [7:0]  m2 [4];
      logic [7:0]  m4 [4];
      logic [7:0]  m8 [4];
      logic [31:0] res;
      logic [1:0]  i1;
      logic [1:0]  i2;
      logic [1:0]  i3;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31 - 8*i -: 8];
         m2[i] = xtime(a[i]);
         m4[i] = xtime(m2[i]);
         m8[i] = xtime(m4[i]);
      end
      for (int i = 0; i < 4; i++) begin
         i1 = 2'(i + 1);
         i2 = 2'(i + 2);
         i3 = 2'(i + 3);
         if (inv) begin
            // 0e.a_i ^ 0b.a_i+1 ^ 0d.a_i+2 ^ 09.a_i+3
            res[31 - 8*i -: 8] = (m8[i]  ^ m4[i]  ^ m2[i])
                               ^ (m8[i1] ^ m2[i1] ^ a[i1])
                               ^ (m8[i2] ^ m4[i2] ^ a[i2])
                               ^ (m8[i3] ^ a[i3]);
         end else begin
            // 02.a_i ^ 03.a_i+1 ^ a_i+2 ^ a_i+3
            res[31 - 8*i -: 8] = m2[i] ^ (m2[i1] ^ a[i1]) ^ a[i2] ^ a[i3];
         end
      end
      return res;
   endfunction

   // Columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 replaced in place; col_cnt
   // is always a multiple of COLS_PER_CYCLE so the 2-bit sum never wraps
   // inside one cycle's group.
   always_comb begin
      logic [1:0] idx;
      int         base;
      work_next = work;
      idx       = '0;
      base      = 0;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         idx  = col_cnt + 2'(j);
         base = 127 - 32 * int'(idx);
         work_next[base -: 32] = mix_col(work[base -: 32], inv_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         work    <= '0;
         inv_q   <= 1'b0;
         col_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  work    <= bus.in_state;
                  inv_q   <= bus.in_inverse;
                  col_cnt <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               work    <= work_next;
               col_cnt <= col_cnt + COL_STEP;
               if (col_cnt == LAST_COL) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // in_ready is forced low while reset is held, even though state already reads IDLE.
   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == DONE);
   assign bus.out_state = work;
   assign bus.busy      = (state != IDLE);
   assign fsm_state     = state;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine
//   Drives three engines (COLS_PER_CYCLE = 1, 2, 4) through a table of
//   directed vectors, backpressure, reset-abort and a forward/inverse stream.
module tb_mix_columns_engine;

   logic clk;
   logic rst;
   int   cyc;

   logic         in_valid   [3];
   logic [127:0] in_state   [3];
   logic         in_inverse [3];
   logic         out_ready  [3];
   logic         in_ready   [3];
   logic         out_valid  [3];
   logic [127:0] out_state  [3];
   logic         busy       [3];
   logic [1:0]   fsm_state  [3];

   int n_vec;
   int n_bad;
   logic [127:0] exp_q[$];

   typedef struct {
      logic [127:0] state;
      logic         inverse;
      logic [127:0] expect_state;
   } vec_t;

   vec_t vecs[7];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT instances ----------------
   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         localparam int CPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
         mix_columns_if u_if ();
         assign u_if.in_valid   = in_valid[g];
         assign u_if.in_state   = in_state[g];
         assign u_if.in_inverse = in_inverse[g];
         assign u_if.out_ready  = out_ready[g];
         assign in_ready[g]     = u_if.in_ready;
         assign out_valid[g]    = u_if.out_valid;
         assign out_state[g]    = u_if.out_state;
         assign busy[g]         = u_if.busy;
         mix_columns_engine #(.COLS_PER_CYCLE(CPC)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (u_if.slave),
            .fsm_state (fsm_state[g])
         );
      end
   endgenerate

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int ncyc(input int g);
      return 4 >> g;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- driver ----------------
   // Offers one block, waits for accept, scrambles the inputs every cycle
   // while the block is in flight, and returns the result once out_valid
   // rises. The output handshake is left to the caller.
   task automatic xfer(input int g, input logic [127:0] st, input logic inv,
                       output logic [127:0] res, output int lat, output int acc);
      int budget;
      in_state[g]   = st;
      in_inverse[g] = inv;
      in_valid[g]   = 1'b1;
      budget = 0;
      @(negedge clk);
      while (!in_ready[g] && budget < 30) begin
         @(negedge clk);
         budget++;
      end
      check($sformatf("accept_ready[%0d]", g), 128'(in_ready[g]), 128'd1);
      acc = cyc;
      @(posedge clk);
      #1;
      in_valid[g] = 1'b0;
      lat = 0;
      while (!out_valid[g] && lat < 30) begin
         in_state[g]   = rand128();
         in_inverse[g] = ~in_inverse[g];
         @(posedge clk);
         #1;
         lat++;
      end
      res = out_state[g];
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [127:0] res;
      logic [127:0] res2;
      logic [127:0] e;
      int lat;
      int acc;
      int prev_acc;
      int stuck;

      n_vec = 0;
      n_bad = 0;
      for (int g = 0; g < 3; g++) begin
         in_valid[g]   = 1'b0;
         in_state[g]   = '0;
         in_inverse[g] = 1'b0;
         out_ready[g]  = 1'b0;
      end

      vecs[0] = '{128'hdb135345_01010101_01010101_01010101, 1'b0,
                  128'h8e4da1bc_01010101_01010101_01010101};
      vecs[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
                  128'h046681e5_e0cb199a_48f8d37a_2806264c};
      vecs[2] = '{128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1,
                  128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
      vecs[3] = '{128'h01010101_01010101_8e4da1bc_01010101, 1'b1,
                  128'h01010101_01010101_db135345_01010101};
      vecs[4] = '{128'h01010101_01010101_01010101_9fdc589d, 1'b1,
                  128'h01010101_01010101_01010101_f20a225c};
      vecs[5] = '{128'hc6c6c6c6_d4d4d4d5_2d26314c_f20a225c, 1'b0,
                  128'hc6c6c6c6_d5d5d7d6_4d7ebdf8_9fdc589d};
      vecs[6] = '{128'hc6c6c6c6_d5d5d7d6_4d7ebdf8_9fdc589d, 1'b1,
                  128'hc6c6c6c6_d4d4d4d5_2d26314c_f20a225c};

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         check($sformatf("rst_out_valid[%0d]", g), 128'(out_valid[g]), 128'd0);
         check($sformatf("rst_busy[%0d]", g), 128'(busy[g]), 128'd0);
         check($sformatf("rst_in_ready[%0d]", g), 128'(in_ready[g]), 128'd0);
         check($sformatf("rst_out_state[%0d]", g), out_state[g], 128'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
         check($sformatf("idle_in_ready[%0d]", g), 128'(in_ready[g]), 128'd1);
      end

      // Table-driven vectors, out_ready held high from before out_valid
      for (int g = 0; g < 3; g++) begin
         out_ready[g] = 1'b1;
         for (int v = 0; v < 7; v++) begin
            xfer(g, vecs[v].state, vecs[v].inverse, res, lat, acc);
            check($sformatf("vec%0d_latency[%0d]", v, g), 128'(lat), 128'(ncyc(g)));
            check($sformatf("vec%0d_state[%0d]", v, g), res, vecs[v].expect_state);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_handshake_valid[%0d]", v, g), 128'(out_valid[g]), 128'd0);
            check($sformatf("vec%0d_handshake_ready[%0d]", v, g), 128'(in_ready[g]), 128'd1);
         end
         out_ready[g] = 1'b0;
      end

      // Backpressure on the 1-column engine
      xfer(0, vecs[1].state, 1'b0, res, lat, acc);
      check("bp_first_state", res, vecs[1].expect_state);
      in_state[0]   = 128'h0123456789abcdef_fedcba9876543210;
      in_inverse[0] = 1'b1;
      in_valid[0]   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("bp_hold_state", out_state[0], vecs[1].expect_state);
         check("bp_hold_valid", 128'(out_valid[0]), 128'd1);
         check("bp_hold_in_ready", 128'(in_ready[0]), 128'd0);
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      check("bp_release_valid", 128'(out_valid[0]), 128'd0);
      check("bp_release_in_ready", 128'(in_ready[0]), 128'd1);
      check("bp_release_busy", 128'(busy[0]), 128'd0);

      // Reset in the middle of a block
      in_state[0]   = vecs[1].state;
      in_inverse[0] = 1'b0;
      in_valid[0]   = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 128'(out_valid[0]), 128'd0);
      check("midrst_busy", 128'(busy[0]), 128'd0);
      check("midrst_in_ready", 128'(in_ready[0]), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready[0] = 1'b1;
      stuck = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (out_valid[0]) stuck++;
      end
      check("midrst_no_output", 128'(stuck), 128'd0);
      xfer(0, 128'hc6c6c6c6_01010101_01010101_01010101, 1'b0, res, lat, acc);
      check("postrst_latency", 128'(lat), 128'd4);
      check("postrst_state", res, 128'hc6c6c6c6_01010101_01010101_01010101);
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;

      // Forward then inverse stream, back-to-back period NCYC+2
      for (int g = 0; g < 3; g++) begin
         out_ready[g] = 1'b1;
         prev_acc = -1;
         for (int i = 0; i < 1000; i++) begin
            e = rand128();
            exp_q.push_back(e);
            xfer(g, e, 1'b0, res, lat, acc);
            if (prev_acc >= 0)
               check($sformatf("period_fwd[%0d]", g), 128'(acc - prev_acc), 128'(ncyc(g) + 2));
            prev_acc = acc;
            @(posedge clk);
            #1;
            xfer(g, res, 1'b1, res2, lat, acc);
            check($sformatf("period_inv[%0d]", g), 128'(acc - prev_acc), 128'(ncyc(g) + 2));
            prev_acc = acc;
            @(posedge clk);
            #1;
            check($sformatf("identity[%0d]", g), res2, exp_q.pop_front());
         end
         out_ready[g] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Iterative, parametrised AES MixColumns / InvMixColumns engine operating on a full 128-bit state.
- It is the successor to the fixed ×3 GF(2^8) lookup. It computes the ×2, ×3, ×9, ×0b, ×0d and ×0e products with xtime logic instead of ROMs.
- It selects forward or inverse mode per block.
- Each cycle it processes a configurable number of columns, with valid/ready handshakes on both sides.
- It sits between the ShiftRows and AddRoundKey stages of the cipher and decipher datapaths.

Parameters:
- COLS_PER_CYCLE, 1: columns transformed per clock. Legal values are 1, 2 and 4. Any other value is an elaboration error.
- NCYC, 4/COLS_PER_CYCLE (derived localparam, not overridable): number of processing cycles per block.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input block valid
- in_ready  out  1  engine can accept a block
- in_state  in  128  input state; byte k = in_state[127-8k -: 8]; column c = bytes 4c..4c+3, byte 4c is row 0
- in_inverse  in  1  0 = MixColumns, 1 = InvMixColumns; sampled only at accept
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_state  out  128  transformed state, same byte ordering as in_state
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE, out_valid=0, out_state=0, busy=0.
  - Column counter and latched mode are cleared.
  - in_ready=0 while rst is high. After release, in_ready=1 combinationally in IDLE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On an edge with in_valid&in_ready, load the working register from in_state, latch in_inverse, clear col_cnt, and go to BUSY.
  - BUSY: in_ready=0. On each edge, replace columns col_cnt..col_cnt+COLS_PER_CYCLE-1 of the working register in place with their transformed values, then add COLS_PER_CYCLE to col_cnt. After the NCYC-th edge, go to DONE.
  - DONE: out_valid=1 and out_state = working register. On an edge with out_valid&out_ready, go to IDLE and deassert out_valid.
- Latency:
  - Accept edge at T gives out_valid high after edge T+NCYC, i.e. 4, 2 or 1 cycles.
  - Minimum block period is NCYC+2 cycles: accept, NCYC processing edges, output handshake.
  - No overlap between blocks; in_ready stays 0 from accept until the output handshake completes.
- out_state:
  - Registered; equals the working register.
  - Stable while out_valid=1 and out_ready=0; backpressure may last indefinitely.
  - In IDLE and BUSY it is don't-care for the consumer, but it must not glitch while out_valid=1.
- Arithmetic, all in GF(2^8) mod x^8+x^4+x^3+x+1:
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
  - ×3 = xtime^a, ×9 = x^3^a, ×0b = x^3^x^a, ×0d = x^3^x^2^a, ×0e = x^3^x^2^x.
  - Forward: r_i = 2·a_i ^ 3·a_(i+1) ^ a_(i+2) ^ a_(i+3).
  - Inverse: r_i = 0e·a_i ^ 0b·a_(i+1) ^ 0d·a_(i+2) ^ 09·a_(i+3).
  - Row indices are taken mod 4.
  - Purely combinational per column; no ROMs and no multi-cycle paths.
- Boundary conditions:
  - in_valid with in_ready=0 is ignored; the upstream must hold it.
  - Changes to in_inverse or in_state after the accept edge have no effect on the block in flight.
  - out_ready high before out_valid has no effect.
  - Reset asserted in BUSY or DONE aborts the block; no output is produced for it.
  - col_cnt never exceeds 3; with COLS_PER_CYCLE=4 the whole state is done in one edge.
  - The forward transform followed by the inverse transform must return the original state bit-exactly.

Test Plan:
- Single column, forward: column 0 = db 13 53 45, others 01 01 01 01 → column 0 = 8e 4d a1 bc, others unchanged 01 01 01 01; out_valid at T+NCYC for each of COLS_PER_CYCLE=1, 2, 4.
- FIPS-197 round 1, forward: in_state 0xd4bf5d30e0b452aeb84111f11e2798e5 → out_state 0x046681e5e0cb199a48f8d37a2806264c.
- Inverse: in_state 0x046681e5e0cb199a48f8d37a2806264c with in_inverse=1 → 0xd4bf5d30e0b452aeb84111f11e2798e5. Additional vectors: column 8e 4d a1 bc → db 13 53 45; column 9f dc 58 9d → f2 0a 22 5c.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_state stable, in_ready=0, new in_valid ignored. Release → handshake, then in_ready=1 on the next cycle.
- Mode latch and back-to-back: toggle in_inverse and in_state every cycle during BUSY → result matches the values captured at accept. Random forward then inverse on 1000 states → identity, with period exactly NCYC+2 when out_ready=1.
- Reset mid-op: assert rst asynchronously during BUSY (between edges) → out_valid=0 and busy=0 immediately. After release, a fresh c6 c6 c6 c6 column yields c6 c6 c6 c6 with correct latency.
